// File: rtl/adc_if_pkg.sv
// Shared definitions for the ADC interface: FSM state encoding and default divider width.
package adc_if_pkg;

    localparam int unsigned DIV_W_DEF = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StRun  = RUN,
        StStop = STOP
    } adc_fwd_state_e;

endpackage

// File: rtl/adc_clk_forward.sv
// Glitch-free programmable forwarded ADC sample clock; every emitted phase is full length.
// Optional first-period sync marker is built when ADC_CLK_FWD_SYNC_EN is defined.
module adc_clk_forward
    import adc_if_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             adc_clk_out,
    output logic             running,
    output logic             sync_out
);

    localparam logic [DIV_W-1:0] CntOne = 1;

    adc_fwd_state_e   r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic             r_clk, w_clk_nxt;
    logic             r_running;
    logic             w_phase_end;

    assign w_phase_end = (r_cnt == r_div);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_clk_nxt   = r_clk;
        unique case (r_state)
            StIdle: begin
                w_cnt_nxt = '0;
                w_clk_nxt = 1'b0;
                if (en) begin
                    w_div_nxt   = div;
                    w_clk_nxt   = 1'b1;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (w_phase_end) begin
                    w_cnt_nxt = '0;
                    w_clk_nxt = ~r_clk;
                    // Stop is only taken at a falling edge, so the last high phase is whole.
                    if (r_clk && !en) begin
                        w_state_nxt = StStop;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CntOne;
                end
            end
            StStop: begin
                w_clk_nxt = 1'b0;
                if (w_phase_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + CntOne;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
                w_clk_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_div     <= '0;
            r_clk     <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_clk     <= w_clk_nxt;
            r_running <= (w_state_nxt == StRun);
        end
    end

    assign adc_clk_out = r_clk;
    assign running     = r_running;

`ifdef ADC_CLK_FWD_SYNC_EN
    logic r_first, w_first_nxt;
    logic r_sync;

    // first spans the initial period: set at start, cleared on the rising edge that ends it.
    always_comb begin
        w_first_nxt = r_first;
        if (r_state == StIdle && en) begin
            w_first_nxt = 1'b1;
        end else if (r_state == StRun && w_phase_end && !r_clk) begin
            w_first_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first <= 1'b0;
            r_sync  <= 1'b0;
        end else begin
            r_first <= w_first_nxt;
            r_sync  <= w_first_nxt && (w_state_nxt == StRun);
        end
    end

    assign sync_out = r_sync;
`else
    assign sync_out = 1'b0;
`endif

endmodule
